spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have no parameters; data width fixed at 8 bits, MSB first.
REQ-002 SHALL provide: i_clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL provide: i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide: i_mode  input  2  {CPOL, CPHA}; sampled only while bus idle.
REQ-005 SHALL provide: i_tx  input  8  byte to return on CIPO.
REQ-006 SHALL provide: i_tx_valid  input  1  load request for i_tx.
REQ-007 SHALL provide: o_tx_ready  output  1  holding register empty, can accept i_tx.
REQ-008 SHALL provide: o_rx  output  8  last complete byte received on COPI.
REQ-009 SHALL provide: o_rx_valid  output  1  one-cycle pulse, o_rx updated.
REQ-010 SHALL provide: i_sclk, i_cs_n, i_copi  input  1 each  asynchronous SPI bus inputs.
REQ-011 SHALL provide: o_cipo  output  1  serial data to controller.
REQ-012 SHALL provide: o_cipo_oe  output  1  CIPO drive enable, high only while selected.
REQ-013 SHALL provide: o_busy  output  1  high while chip select active.

Function
REQ-014 i_sclk, i_cs_n, i_copi SHALL each pass through a 2-flop synchronizer; a third registered sclk stage provides edge detection.
REQ-015 Correct operation SHALL be guaranteed for SCLK high and low phases each >= 4 i_clk periods; faster SCLK is unsupported.
REQ-016 Leading edge = idle-to-active SCLK transition per CPOL (CPOL=0 rising, CPOL=1 falling); trailing edge is the opposite.
REQ-017 FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs_n falling, ACTIVE->IDLE on synchronized cs_n high.
REQ-018 On IDLE->ACTIVE: latch i_mode into internal mode register, clear 3-bit bit counter, load TX shift register from holding register.
REQ-019 CPHA=0: o_cipo SHALL present MSB in the cycle after cs_n fall detection; sample COPI on leading edges; shift CIPO on trailing edges.
REQ-020 CPHA=1: shift CIPO (first shift presents MSB) on leading edges; sample COPI on trailing edges.
REQ-021 Each sample SHALL shift COPI into RX shift register LSB and increment bit counter modulo 8.
REQ-022 On the 8th sample: o_rx <= completed byte and o_rx_valid high exactly 1 cycle, next cycle after the sampling edge detection; no host backpressure, new byte overwrites o_rx.
REQ-023 After the 8th sample, TX shift register SHALL reload from holding register for the next byte in the same selection (back-to-back bytes supported).
REQ-024 Holding register: i_tx_valid while o_tx_ready=1 loads i_tx and clears o_tx_ready next cycle; i_tx_valid while o_tx_ready=0 SHALL be ignored.
REQ-025 Transfer of the holding register into the TX shift register SHALL set o_tx_ready=1 next cycle; simultaneous load and transfer: transfer uses old contents, new i_tx is accepted.
REQ-026 Underrun: if the holding register is empty at load time, TX shift register SHALL load 8'h00.
REQ-027 cs_n deassertion mid-byte SHALL discard the partial RX byte (no o_rx_valid), reset bit counter, keep o_rx unchanged; holding register contents retained.
REQ-028 SCLK edges while IDLE SHALL be ignored; i_mode changes while ACTIVE SHALL be ignored.
REQ-029 o_cipo_oe and o_busy SHALL equal 1 exactly in state ACTIVE; o_cipo SHALL be 0 when o_cipo_oe=0.

Reset
REQ-030 On i_clk edge with i_rst_n=0: state IDLE, synchronizers cleared (cs_n stages set to 1, sclk stages to 0), o_rx=8'h00, o_rx_valid=0, o_tx_ready=1, o_cipo=0, o_cipo_oe=0, o_busy=0, holding register empty, mode register 2'b00.
REQ-031 Reset asserted mid-transfer SHALL abort immediately; after release, the block SHALL wait for a fresh cs_n falling edge before responding.

Verification
REQ-032 Mode 0, i_tx=8'hA5 loaded, controller sends 8'h3C -> CIPO bits 1,0,1,0,0,1,0,1; o_rx=8'h3C with one o_rx_valid pulse; o_tx_ready returns 1.
REQ-033 Modes 1, 2, 3 each with TX 8'hC3, RX 8'h5A -> same bytes exchanged, sampling on the edge defined by REQ-019/020.
REQ-034 Two back-to-back bytes under one cs_n low, second i_tx=8'h0F loaded during byte 1 -> CIPO sends 8'hA5 then 8'h0F; two o_rx_valid pulses.
REQ-035 No i_tx loaded, controller sends 8'hFF -> CIPO all zeros; o_rx=8'hFF.
REQ-036 cs_n raised after 5 SCLK cycles -> no o_rx_valid, o_busy falls; next full byte 8'h81 received correctly.
REQ-037 i_rst_n low for 1 cycle mid-byte -> all outputs at REQ-030 values; SCLK toggling with cs_n still low produces no o_rx_valid.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: host-side handshake and SPI bus signals of the SPI peripheral
interface spi_peripheral_if;
  logic [1:0] i_mode;
  logic [7:0] i_tx;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx;
  logic       o_rx_valid;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_copi;
  logic       o_cipo;
  logic       o_cipo_oe;
  logic       o_busy;
  modport slave (
    input  i_mode, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
    output o_tx_ready, o_rx, o_rx_valid, o_cipo, o_cipo_oe, o_busy
  );
  modport master (
    output i_mode, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
    input  o_tx_ready, o_rx, o_rx_valid, o_cipo, o_cipo_oe, o_busy
  );
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: 8-bit MSB-first SPI peripheral, all four modes, oversampled by i_clk
module spi_peripheral (
  input logic             i_clk,
  input logic             i_rst_n,
  spi_peripheral_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic sclk_s1, sclk_s2, sclk_s3, cs_s1, cs_s2, copi_s1, copi_s2;
  logic rst_q, armed, hold_full, cipo_q, rx_valid, cpha;
  logic start, stop, act, rise, fall, lead, trail, sample, shift, reload, take, accept;
  logic [1:0] mode;
  logic [2:0] cnt;
  logic [7:0] hold, tx_sh, rx_sh, rx, nxt_byte;

  // Synchronizers; armed requires cs_n seen high after reset so a held-low select is not taken as a fresh edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      {sclk_s1, sclk_s2, sclk_s3} <= '0;
      {cs_s1, cs_s2} <= '1;
      {copi_s1, copi_s2} <= '0;
      rst_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {bus.i_sclk, sclk_s1, sclk_s2};
      {cs_s1, cs_s2} <= {bus.i_cs_n, cs_s1};
      {copi_s1, copi_s2} <= {bus.i_copi, copi_s1};
      rst_q <= 1'b1;
      armed <= armed | (rst_q & cs_s1);
    end
  end

  // Next state plus edge qualification; CPHA=0 reloads on the trailing edge after the 8th sample so the new MSB is not shifted away
  always_comb begin
    start = state == IDLE && armed && !cs_s2;
    stop = state == ACTIVE && cs_s2;
    act = state == ACTIVE && !cs_s2;
    rise = sclk_s2 && !sclk_s3;
    fall = !sclk_s2 && sclk_s3;
    lead = act && (mode[1] ? fall : rise);
    trail = act && (mode[1] ? rise : fall);
    sample = mode[0] ? trail : lead;
    shift = mode[0] ? lead : trail && cnt != 3'd0;
    reload = trail && cnt == (mode[0] ? 3'd7 : 3'd0);
    take = start || reload;
    accept = bus.i_tx_valid && !hold_full;
    nxt_byte = hold_full ? hold : 8'h00;
    cpha = start ? bus.i_mode[0] : mode[0];
    state_nx = start ? ACTIVE : stop ? IDLE : state;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // Holding register, shift registers, bit counter and received-byte output
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode <= 2'b00;
      cnt <= 3'd0;
      hold <= 8'h00;
      hold_full <= 1'b0;
      tx_sh <= 8'h00;
      cipo_q <= 1'b0;
      rx_sh <= 8'h00;
      rx <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      hold_full <= take ? accept : hold_full | accept;
      if (accept) hold <= bus.i_tx;
      if (start) mode <= bus.i_mode;
      if (start || stop) cnt <= 3'd0;
      else if (sample) cnt <= cnt + 3'd1;
      if (sample) rx_sh <= {rx_sh[6:0], copi_s2};
      if (sample && cnt == 3'd7) begin
        rx <= {rx_sh[6:0], copi_s2};
        rx_valid <= 1'b1;
      end
      if (take) {cipo_q, tx_sh} <= cpha ? {cipo_q, nxt_byte} : {nxt_byte, 1'b0};
      else if (shift) {cipo_q, tx_sh} <= {tx_sh, 1'b0};
    end
  end

  assign bus.o_tx_ready = !hold_full;
  assign bus.o_rx = rx;
  assign bus.o_rx_valid = rx_valid;
  assign bus.o_busy = state == ACTIVE;
  assign bus.o_cipo_oe = state == ACTIVE;
  assign bus.o_cipo = state == ACTIVE && cipo_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: randomized SPI controller against a byte-level model with an rx scoreboard
module tb_spi_peripheral;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_peripheral_if bus();
  spi_peripheral dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_rx[$];
  logic       mfull;
  logic [7:0] mval, exp_next;
  logic [1:0] cur_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic consume();
    exp_next = mfull ? mval : 8'h00;
    mfull = 1'b0;
  endtask

  task automatic load(input logic [7:0] b);
    logic acc;
    chk("tx_ready_before_load", bus.o_tx_ready, !mfull);
    acc = !mfull;
    bus.i_tx = b;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
    if (acc) begin
      mfull = 1'b1;
      mval = b;
    end
    chk("tx_ready_after_load", bus.o_tx_ready, !mfull);
  endtask

  task automatic select(input logic [1:0] m);
    cur_mode = m;
    bus.i_mode = m;
    bus.i_sclk = m[1];
    repeat (4) @(negedge clk);
    bus.i_cs_n = 1'b0;
    half();
    chk("busy_selected", bus.o_busy, 1);
    chk("oe_selected", bus.o_cipo_oe, 1);
    consume();
    bus.i_mode = 2'($urandom);
  endtask

  task automatic deselect();
    half();
    bus.i_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_released", bus.o_busy, 0);
    chk("oe_released", bus.o_cipo_oe, 0);
    chk("cipo_released", bus.o_cipo, 0);
    chk("tx_ready_idle", bus.o_tx_ready, !mfull);
  endtask

  task automatic xfer(input logic [7:0] rxb, input int nbits, input logic do_ld, input logic [7:0] ldb);
    logic [7:0] cap;
    logic cpol, cph;
    cap = 8'h00;
    cpol = cur_mode[1];
    cph = cur_mode[0];
    if (nbits == 8) exp_rx.push_back(rxb);
    for (int i = 0; i < nbits; i++) begin
      if (do_ld && i == 3) load(ldb);
      if (!cph) begin
        bus.i_copi = rxb[7-i];
        half();
        cap[7-i] = bus.o_cipo;
        bus.i_sclk = ~cpol;
        half();
        bus.i_sclk = cpol;
      end else begin
        bus.i_sclk = ~cpol;
        bus.i_copi = rxb[7-i];
        half();
        cap[7-i] = bus.o_cipo;
        bus.i_sclk = cpol;
        half();
      end
    end
    if (!cph) half();
    if (nbits == 8) begin
      chk("cipo_byte", cap, exp_next);
      consume();
    end
  endtask

  task automatic chk_reset();
    chk("rst_rx", bus.o_rx, 0);
    chk("rst_rx_valid", bus.o_rx_valid, 0);
    chk("rst_tx_ready", bus.o_tx_ready, 1);
    chk("rst_cipo", bus.o_cipo, 0);
    chk("rst_oe", bus.o_cipo_oe, 0);
    chk("rst_busy", bus.o_busy, 0);
  endtask

  always @(negedge clk) begin
    if (bus.o_rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got rx_valid with o_rx=%0h, none expected", bus.o_rx);
      end else chk("rx_byte", bus.o_rx, exp_rx.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rm;
    int nb;
    rst_n = 1'b0;
    bus.i_mode = 2'b00;
    bus.i_tx = 8'h00;
    bus.i_tx_valid = 1'b0;
    bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_copi = 1'b0;
    mfull = 1'b0;
    mval = 8'h00;
    exp_next = 8'h00;
    cur_mode = 2'b00;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    load(8'hA5);
    select(2'b00);
    xfer(8'h3C, 8, 1'b0, 8'h00);
    deselect();

    for (int m = 1; m < 4; m++) begin
      load(8'hC3);
      select(2'(m));
      xfer(8'h5A, 8, 1'b0, 8'h00);
      deselect();
    end

    load(8'hA5);
    select(2'b00);
    xfer(8'h96, 8, 1'b1, 8'h0F);
    xfer(8'h69, 8, 1'b0, 8'h00);
    deselect();

    select(2'b00);
    xfer(8'hFF, 8, 1'b0, 8'h00);
    deselect();

    load(8'h11);
    load(8'h22);
    select(2'b00);
    xfer(8'hB7, 5, 1'b1, 8'h3E);
    deselect();
    select(2'b00);
    xfer(8'h81, 8, 1'b0, 8'h00);
    deselect();

    select(2'b00);
    xfer(8'h55, 3, 1'b0, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    mfull = 1'b0;
    rst_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      bus.i_sclk = ~bus.i_sclk;
      bus.i_copi = 1'($urandom);
      half();
    end
    chk("busy_after_reset", bus.o_busy, 0);
    bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;
    half();
    load(8'h96);
    select(2'b01);
    xfer(8'hE7, 8, 1'b0, 8'h00);
    deselect();

    for (int t = 0; t < 20; t++) begin
      rm = 2'($urandom);
      if ($urandom_range(1, 0) == 1) load(8'($urandom));
      select(rm);
      nb = $urandom_range(3, 1);
      for (int k = 0; k < nb; k++) xfer(8'($urandom), 8, 1'($urandom), 8'($urandom));
      deselect();
    end

    repeat (10) @(negedge clk);
    chk("rx_queue_empty", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
